// File: rtl/d_latch_array_pkg.sv
// Shared defaults and the per-bit next-value rule for the synchronous D latch array.
// The r > s > d priority in next_bit is only used when D_LATCH_SR_INPUT_EN is defined.
package d_latch_pkg;

  localparam int DEFAULT_WIDTH     = 1;
  localparam int DEFAULT_RESET_VAL = 0;

  // A forbidden s=r=1 input resolves to 0 because r wins.
  function automatic logic next_bit(input logic d, input logic s, input logic r);
    logic nb;
    nb = d;
    if (r) begin
      nb = 1'b0;
    end else if (s) begin
      nb = 1'b1;
    end
    return nb;
  endfunction

endpackage

// File: rtl/d_latch_array_if.sv
// Bus bundle for d_latch_array: enable, data, optional set/reset lines and complementary outputs.
// The s/r lines are present only when D_LATCH_SR_INPUT_EN is defined.
interface d_latch_array_if #(
  parameter int WIDTH = 1
);

  logic             en;
  logic [WIDTH-1:0] d;
`ifdef D_LATCH_SR_INPUT_EN
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

`ifdef D_LATCH_SR_INPUT_EN
  modport master (output en, d, s, r, input q, qbar);
  modport slave  (input en, d, s, r, output q, qbar);
`else
  modport master (output en, d, input q, qbar);
  modport slave  (input en, d, output q, qbar);
`endif

endinterface

// File: rtl/d_latch_array_cell.sv
// One latch bit: held flop, transparent mux, reset override and qbar inverter.
// Reset forces the output immediately, so q and qbar never agree even during reset.
module d_latch_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_d,
  output logic o_q,
  output logic o_qbar
);

  logic r_held;
  logic w_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held <= RESET_BIT;
    end else if (i_en) begin
      r_held <= i_d;
    end
  end

  // Zero-latency output: transparent while enabled, held value otherwise.
  always_comb begin
    w_q = r_held;
    if (!rst_n) begin
      w_q = RESET_BIT;
    end else if (i_en) begin
      w_q = i_d;
    end
  end

  assign o_q    = w_q;
  assign o_qbar = ~w_q;

endmodule

// File: rtl/d_latch_array.sv
// WIDTH-bit gated D latch built from one clock domain, no latch cells.
// Optional per-bit set/reset override is enabled by defining D_LATCH_SR_INPUT_EN.
module d_latch_array
  import d_latch_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
  input logic              clk,
  input logic              rst_n,
  d_latch_array_if.slave   bus
);

  logic [WIDTH-1:0] w_dEff;

  // s/r only matter while en=1; with en=0 the cells ignore w_dEff entirely.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
`ifdef D_LATCH_SR_INPUT_EN
      w_dEff[i] = next_bit(bus.d[i], bus.s[i], bus.r[i]);
`else
      w_dEff[i] = bus.d[i];
`endif
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    d_latch_cell #(
      .RESET_BIT (RESET_VAL[g])
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (bus.en),
      .i_d    (w_dEff[g]),
      .o_q    (bus.q[g]),
      .o_qbar (bus.qbar[g])
    );
  end

endmodule

// File: tb/tb_d_latch_array.sv
// Scoreboard bench for d_latch_array: stimulus pushes hand-computed q values, a monitor pops and compares.
// SR override vectors are included when D_LATCH_SR_INPUT_EN is defined.
module tb_d_latch_array;

  localparam int               W    = 4;
  localparam logic [W-1:0]     RVAL = 4'h0;

  typedef struct {
    logic [W-1:0] q;
    string        name;
  } exp_t;

  logic   clk;
  logic   rst_n;
  exp_t   expQ[$];
  int     checks;
  int     errors;

  d_latch_array_if #(.WIDTH(W)) bus ();

  d_latch_array #(
    .WIDTH     (W),
    .RESET_VAL (RVAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the expected output.
  task automatic applyStimulus(input logic rst, input logic en, input logic [W-1:0] d,
                               input logic [W-1:0] s, input logic [W-1:0] r,
                               input logic [W-1:0] q, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = rst;
    bus.en = en;
    bus.d  = d;
`ifdef D_LATCH_SR_INPUT_EN
    bus.s  = s;
    bus.r  = r;
`else
    if (s != r) begin
      // s/r only exist in the SR build
    end
`endif
    e.q    = q;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.q !== e.q) begin
      errors++;
      $display("[TB] FAIL %s q: got %h expected %h", e.name, bus.q, e.q);
    end
    checks++;
    if (bus.qbar !== ~e.q) begin
      errors++;
      $display("[TB] FAIL %s qbar: got %h expected %h", e.name, bus.qbar, ~e.q);
    end
  endtask

  // Monitor: the output is combinational, so every queued cycle is compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.d  = '0;
`ifdef D_LATCH_SR_INPUT_EN
    bus.s  = '0;
    bus.r  = '0;
`endif

    // Reset dominates en/d, then held stays at RESET_VAL.
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, "rst_a");
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, "rst_b");
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, "rst_release_hold");

    // Transparency.
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "transp_0");
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, "transp_F");
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "transp_0b");
    applyStimulus(1'b1, 1'b1, 4'hA, 4'h0, 4'h0, 4'hA, "transp_A");

    // Hold: last transparent d was F; later d changes are ignored.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, "hold_load");
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF, "hold_close");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, "hold_d0");
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 4'h0, 4'hF, "hold_d5");
    applyStimulus(1'b1, 1'b0, 4'hA, 4'h0, 4'h0, 4'hF, "hold_dA");
    applyStimulus(1'b1, 1'b0, 4'h3, 4'h0, 4'h0, 4'hF, "hold_d3");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, "hold_d0b");

    // Reopen with d=0, then confirm the captured value.
    applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, "reopen");
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, "reopen_held");

    // Reset in the middle of transparency.
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'hF, "mid_transp");
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, "mid_rst");
    applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, "mid_release");
    applyStimulus(1'b1, 1'b0, 4'h5, 4'h0, 4'h0, 4'h0, "mid_release_b");
    applyStimulus(1'b1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h5, "mid_reopen");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h5, "mid_held");

    // Mixed bit pattern across the width.
    applyStimulus(1'b1, 1'b1, 4'h6, 4'h0, 4'h0, 4'h6, "mixed_open");
    applyStimulus(1'b1, 1'b0, 4'h9, 4'h0, 4'h0, 4'h6, "mixed_held");

`ifdef D_LATCH_SR_INPUT_EN
    applyStimulus(1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF, "sr_set");
    applyStimulus(1'b1, 1'b1, 4'h0, 4'hF, 4'hF, 4'h0, "sr_both");
    applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, 4'h5, 4'hA, "sr_clear");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 4'hA, "sr_ignored");
    applyStimulus(1'b1, 1'b1, 4'h3, 4'h4, 4'h1, 4'h6, "sr_mixed");
    applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'h6, "sr_mixed_held");
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
